// File: rtl/scan_sel_gen_pkg.sv
// Shared definitions for the 4-way scan sequencers: state encoding and
// dwell/blank counter sizing.
package scan_sel_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Counter must hold the largest slot length without wrapping.
  function automatic int cnt_width(input int dwell_cyc, input int blank_cyc);
    int m;
    m = (dwell_cyc > blank_cyc) ? dwell_cyc : blank_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Cyclic priority search: first set mask bit at cur+1, cur+2, cur+3, then cur.
// wrap flags a step that does not move to a higher index (new frame).
module scan_next_idx (
  input  logic [1:0] cur,
  input  logic [3:0] mask,
  output logic [1:0] nxt,
  output logic       wrap,
  output logic       none
);

  logic [1:0] idx;

  always_comb begin
    nxt  = cur;
    idx  = cur;
    none = ~|mask;
    // Walk from lowest to highest priority so the nearest forward hit wins.
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) nxt = idx;
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Select sequencer feeding a 2-to-4 decoder: dwells on each enabled index,
// blanks between indices, skips masked ones and marks each frame start.
module scan_sel_gen
  import scan_sel_gen_pkg::*;
#(
  parameter int DWELL_CYC = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       frame_tick
);

  localparam int CNT_W = cnt_width(DWELL_CYC, BLANK_CYC);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

  scan_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel_n;
  logic             valid_n, tick_n;
  logic             do_adv;

  logic [1:0] search_cur, nxt;
  logic       wrap, none;

  // From IDLE, searching after index 3 yields the lowest set bit.
  assign search_cur = (state == ST_IDLE) ? 2'd3 : sel;

  scan_next_idx u_next_idx (
    .cur  (search_cur),
    .mask (mask),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    valid_n = 1'b0;
    tick_n  = 1'b0;
    do_adv  = 1'b0;

    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!none) begin
            state_n = ST_DWELL;
            cnt_n   = '0;
            sel_n   = nxt;
            valid_n = 1'b1;
            tick_n  = 1'b1;
          end
        end
        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            if (BLANK_CYC > 0) begin
              state_n = ST_BLANK;
              cnt_n   = '0;
            end else begin
              do_adv = 1'b1;
            end
          end else begin
            cnt_n   = cnt + CNT_W'(1);
            valid_n = 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) do_adv = 1'b1;
          else                   cnt_n  = cnt + CNT_W'(1);
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase

      // Mask is only consulted here, so mid-slot changes never cut a slot short.
      if (do_adv) begin
        cnt_n = '0;
        if (none) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DWELL;
          sel_n   = nxt;
          valid_n = 1'b1;
          tick_n  = wrap;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel        <= 2'b00;
      sel_valid  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      sel_valid  <= valid_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen (DWELL_CYC=4, BLANK_CYC=1) plus a
// BLANK_CYC=0 instance for the gapless case.
module tb_scan_sel_gen;

  localparam int DW = 4;
  localparam int BL = 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] mask;
  logic [1:0] sel, nb_sel;
  logic       sel_valid, nb_valid;
  logic       frame_tick, nb_tick;

  int n_tests;
  int n_fail;

  // Expected per-cycle {sel[1:0], sel_valid, frame_tick}
  logic [3:0] exp_q[$];

  scan_sel_gen #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mask       (mask),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .frame_tick (frame_tick)
  );

  scan_sel_gen #(.DWELL_CYC(DW), .BLANK_CYC(0)) dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mask       (mask),
    .sel        (nb_sel),
    .sel_valid  (nb_valid),
    .frame_tick (nb_tick)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'b0000;
    repeat (2) step();
    check("reset", {28'd0, sel, sel_valid, frame_tick}, 32'd0);
    rst_n = 1'b1;
  endtask

  // ---- driver / scoreboard helpers ----
  task automatic push_slot(input logic [1:0] s, input logic tick);
    for (int i = 0; i < DW; i++) exp_q.push_back({s, 1'b1, (i == 0) ? tick : 1'b0});
    for (int i = 0; i < BL; i++) exp_q.push_back({s, 1'b0, 1'b0});
  endtask

  task automatic run_q(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check(tag, {28'd0, sel, sel_valid, frame_tick}, {28'd0, e});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // 1: full mask, 0-1-2-3-0 with frame_tick at t=0 and t=20
    do_reset();
    en = 1'b1; mask = 4'b1111;
    push_slot(2'd0, 1'b1); push_slot(2'd1, 1'b0);
    push_slot(2'd2, 1'b0); push_slot(2'd3, 1'b0);
    push_slot(2'd0, 1'b1);
    run_q("full_mask");

    // 2: mask 1010 alternates 1,3 with a tick on each return to 1
    do_reset();
    en = 1'b1; mask = 4'b1010;
    push_slot(2'd1, 1'b1); push_slot(2'd3, 1'b0);
    push_slot(2'd1, 1'b1); push_slot(2'd3, 1'b0);
    run_q("mask_1010");

    // 3: single bit re-dwells on index 2, tick every period
    do_reset();
    en = 1'b1; mask = 4'b0100;
    push_slot(2'd2, 1'b1); push_slot(2'd2, 1'b1); push_slot(2'd2, 1'b1);
    run_q("single_bit");

    // 4: en drop on 2nd dwell cycle of sel=2, then re-enable
    do_reset();
    en = 1'b1; mask = 4'b1111;
    push_slot(2'd0, 1'b1); push_slot(2'd1, 1'b0);
    exp_q.push_back({2'd2, 1'b1, 1'b0});
    exp_q.push_back({2'd2, 1'b1, 1'b0});
    run_q("pre_disable");
    en = 1'b0;
    exp_q.push_back({2'd2, 1'b0, 1'b0});
    exp_q.push_back({2'd2, 1'b0, 1'b0});
    run_q("disabled");
    en = 1'b1;
    exp_q.push_back({2'd0, 1'b1, 1'b1});
    exp_q.push_back({2'd0, 1'b1, 1'b0});
    run_q("reenable");

    // 5a: enabled with empty mask stays idle
    do_reset();
    en = 1'b1; mask = 4'b0000;
    repeat (3) exp_q.push_back({2'd0, 1'b0, 1'b0});
    run_q("empty_mask");
    // 5b: mask cleared mid-dwell: slot completes, then idle
    mask = 4'b0001;
    exp_q.push_back({2'd0, 1'b1, 1'b1});
    exp_q.push_back({2'd0, 1'b1, 1'b0});
    run_q("mask_clr_pre");
    mask = 4'b0000;
    exp_q.push_back({2'd0, 1'b1, 1'b0});
    exp_q.push_back({2'd0, 1'b1, 1'b0});
    exp_q.push_back({2'd0, 1'b0, 1'b0});
    exp_q.push_back({2'd0, 1'b0, 1'b0});
    exp_q.push_back({2'd0, 1'b0, 1'b0});
    run_q("mask_clr_post");

    // 5c: gapless build keeps sel_valid high across index changes
    do_reset();
    en = 1'b1; mask = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      step();
      check("nb_valid", {31'd0, nb_valid}, 32'd1);
      check("nb_sel", {30'd0, nb_sel}, (c / DW) % 4);
      check("nb_tick", {31'd0, nb_tick}, (c % 16 == 0) ? 32'd1 : 32'd0);
    end

    // 6: asynchronous reset between edges mid-dwell on sel=1
    do_reset();
    en = 1'b1; mask = 4'b1111;
    repeat (7) step();
    check("pre_async", {28'd0, sel, sel_valid, frame_tick}, {28'd0, 2'd1, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {28'd0, sel, sel_valid, frame_tick}, 32'd0);
    #1 rst_n = 1'b1;
    exp_q.push_back({2'd0, 1'b1, 1'b1});
    exp_q.push_back({2'd0, 1'b1, 1'b0});
    run_q("post_async");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
